// File: rtl/intr_pkg.sv
// intr_pkg: shared sizes, index/vector types and arbiter FSM states for intr_arbiter
package intr_pkg;
  localparam int NINTR = 32;
  localparam int VW = 12;
  typedef logic [4:0] intr_num_t;
  typedef logic [VW-1:0] intr_vec_t;
  typedef enum logic [1:0] {IDLE, REQ, SERV} intr_state_t;
endpackage

// File: rtl/prio_enc32.sv
// prio_enc32: find-first-set over 32 bits, index 0 has highest priority
module prio_enc32 (
  input  logic [31:0] bits,
  output logic        valid,
  output logic [4:0]  idx
);
  // scan from the bottom of the priority order so the lowest set index is written last
  always_comb begin
    valid = |bits;
    idx = '0;
    for (int i = 31; i >= 0; i--) if (bits[i]) idx = 5'(i);
  end
endmodule

// File: rtl/intr_arbiter.sv
// intr_arbiter: sticky pending/mask/in-service interrupt arbiter with vector table and req/ack handshake; INTR_NEST_EN enables nesting
module intr_arbiter #(
  parameter int NINTR = intr_pkg::NINTR,
  parameter int VW = intr_pkg::VW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NINTR-1:0] i_irq,
  input  logic             i_mask_we,
  input  logic [NINTR-1:0] i_mask_data,
  input  logic             i_tab_we,
  input  logic [4:0]       i_tab_idx,
  input  logic [VW-1:0]    i_tab_data,
  input  logic             i_ien,
  input  logic             i_ack,
  input  logic             i_eoi,
  output logic             o_req,
  output logic [4:0]       o_num,
  output logic [VW-1:0]    o_vector,
  output logic [NINTR-1:0] o_pending,
  output logic [NINTR-1:0] o_inserv
);
  import intr_pkg::*;
  intr_state_t state, state_n;
  logic [NINTR-1:0] mask, eligible, ack_clr, eoi_clr;
  logic [VW-1:0] tab [NINTR];
  logic win_v, top_v, nest_ok, ack_fire, eoi_fire, withdraw;
  intr_num_t win_idx, top_idx;
  assign eligible = o_pending & ~mask & {NINTR{i_ien}};
  prio_enc32 u_win (.bits(eligible), .valid(win_v), .idx(win_idx));
  prio_enc32 u_top (.bits(o_inserv), .valid(top_v), .idx(top_idx));
  assign ack_fire = state == REQ && i_ack;
  assign withdraw = state == REQ && !i_ack && (!i_ien || mask[o_num]);
  assign eoi_fire = state == SERV && i_eoi && top_v;
  assign ack_clr = ack_fire ? {{(NINTR-1){1'b0}}, 1'b1} << o_num : '0;
  assign eoi_clr = eoi_fire ? {{(NINTR-1){1'b0}}, 1'b1} << top_idx : '0;
`ifdef INTR_NEST_EN
  assign nest_ok = win_v && win_idx < top_idx;
`else
  assign nest_ok = 1'b0;
`endif
  // next state: eoi in SERV takes the cycle, so a nested presentation waits one edge
  always_comb begin
    state_n = state == IDLE ? (win_v ? REQ : IDLE)
            : state == REQ  ? (ack_fire ? SERV : withdraw ? (|o_inserv ? SERV : IDLE) : REQ)
            : eoi_fire      ? (|(o_inserv & ~eoi_clr) ? SERV : IDLE)
            : nest_ok       ? REQ : SERV;
  end
  // state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_n;
  end
  // pending/in-service bookkeeping, table/mask writes, and latching of the presented source
  always_ff @(posedge clk) begin
    if (reset) begin
      o_pending <= '0;
      o_inserv <= '0;
      mask <= '0;
      o_req <= 1'b0;
      o_num <= '0;
      o_vector <= '0;
      for (int i = 0; i < NINTR; i++) tab[i] <= '0;
    end else begin
      o_pending <= (o_pending & ~ack_clr) | i_irq;
      o_inserv <= (o_inserv | ack_clr) & ~eoi_clr;
      o_req <= state_n == REQ;
      if (i_mask_we) mask <= i_mask_data;
      if (i_tab_we) tab[i_tab_idx] <= i_tab_data;
      if (state != REQ && state_n == REQ) begin
        o_num <= win_idx;
        o_vector <= tab[win_idx];
      end
    end
  end
endmodule

// File: tb/tb_intr_arbiter.sv
// tb_intr_arbiter: vector table, corner sequences and randomized run against a rule-level model
module tb_intr_arbiter;
`ifdef INTR_NEST_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif
  logic clk = 1'b0, reset;
  logic [31:0] i_irq, i_mask_data, o_pending, o_inserv;
  logic i_mask_we, i_tab_we, i_ien, i_ack, i_eoi, o_req;
  logic [4:0] i_tab_idx, o_num;
  logic [11:0] i_tab_data, o_vector;
  int tests = 0, fails = 0;
  logic [31:0] m_pend, m_mask, m_ins;
  logic [11:0] m_tab [32];
  logic m_req;
  logic [4:0] m_num;
  logic [11:0] m_vec;
  typedef struct {
    string name;
    logic [31:0] irq;
    logic ack, eoi, ien, mwe;
    logic [31:0] mdata;
    logic req;
    logic [4:0] num;
    logic [11:0] vec;
    logic [31:0] pend, ins;
  } vec_t;
  vec_t vecs [$];

  always #5 clk = ~clk;

  intr_arbiter dut (
    .clk(clk), .reset(reset), .i_irq(i_irq), .i_mask_we(i_mask_we), .i_mask_data(i_mask_data),
    .i_tab_we(i_tab_we), .i_tab_idx(i_tab_idx), .i_tab_data(i_tab_data), .i_ien(i_ien),
    .i_ack(i_ack), .i_eoi(i_eoi), .o_req(o_req), .o_num(o_num), .o_vector(o_vector),
    .o_pending(o_pending), .o_inserv(o_inserv)
  );

  function automatic logic [81:0] snap();
    return {o_req, o_num, o_vector, o_pending, o_inserv};
  endfunction

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 32;
  endfunction

  task automatic check(input string name, input logic [81:0] got, input logic [81:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got req=%0b num=%0d vec=%h pend=%h ins=%h, want req=%0b num=%0d vec=%h pend=%h ins=%h",
               name, got[81], got[80:76], got[75:64], got[63:32], got[31:0],
               exp[81], exp[80:76], exp[75:64], exp[63:32], exp[31:0]);
    end
  endtask

  task automatic check1(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  // advance the model by the rules: one presentation at a time, ack moves pending to in-service
  task automatic model_step();
    logic [31:0] elig;
    int w, t;
    logic ak, wd, eo, pres;
    if (reset) begin
      m_pend = '0; m_mask = '0; m_ins = '0; m_req = 1'b0; m_num = '0; m_vec = '0;
      for (int i = 0; i < 32; i++) m_tab[i] = '0;
      return;
    end
    elig = m_pend & ~m_mask & {32{i_ien}};
    w = lowest(elig);
    t = lowest(m_ins);
    ak = m_req && i_ack;
    wd = m_req && !i_ack && (!i_ien || m_mask[m_num]);
    eo = !m_req && i_eoi && m_ins != 0;
    pres = !m_req && !eo && w < 32 && (m_ins == 0 || (NEST && w < t));
    if (ak) begin
      m_pend[m_num] = 1'b0;
      m_ins[m_num] = 1'b1;
    end
    if (pres) begin
      m_num = 5'(w);
      m_vec = m_tab[w];
    end
    m_req = pres || (m_req && !ak && !wd);
    m_pend = m_pend | i_irq;
    if (eo) m_ins[t] = 1'b0;
    if (i_mask_we) m_mask = i_mask_data;
    if (i_tab_we) m_tab[i_tab_idx] = i_tab_data;
  endtask

  task automatic tick(input string name);
    model_step();
    @(posedge clk);
    #1;
    check({name, "_model"}, snap(), {m_req, m_num, m_vec, m_pend, m_ins});
  endtask

  task automatic idle_in();
    i_irq = '0; i_ack = 1'b0; i_eoi = 1'b0; i_mask_we = 1'b0; i_tab_we = 1'b0;
  endtask

  task automatic tab_write(input logic [4:0] idx, input logic [11:0] data);
    idle_in();
    i_tab_we = 1'b1; i_tab_idx = idx; i_tab_data = data;
    tick("tab_wr");
    i_tab_we = 1'b0;
  endtask

  task automatic add(input string n, input logic [31:0] irq, input logic ack, input logic eoi,
                     input logic ien, input logic mwe, input logic [31:0] md, input logic req,
                     input logic [4:0] num, input logic [11:0] vec, input logic [31:0] pend,
                     input logic [31:0] ins);
    vecs.push_back('{n, irq, ack, eoi, ien, mwe, md, req, num, vec, pend, ins});
  endtask

  initial begin
    reset = 1'b1; i_ien = 1'b1; i_mask_data = '0; i_tab_idx = '0; i_tab_data = '0;
    idle_in();
    #1;
    tick("reset");
    tick("reset");
    check("reset_state", snap(), '0);
    reset = 1'b0;
    tab_write(5'd5, 12'h44E);
    //   name            irq        ak eo ien mwe mdata   req num vec     pend       ins
    add("t1_irq5",     32'h20,    0, 0, 1, 0, 0,      0,  0, 12'h000, 32'h20,    32'h0);
    add("t1_req",      32'h0,     0, 0, 1, 0, 0,      1,  5, 12'h44E, 32'h20,    32'h0);
    add("t1_ack",      32'h0,     1, 0, 1, 0, 0,      0,  5, 12'h44E, 32'h0,     32'h20);
    add("t1_eoi",      32'h0,     0, 1, 1, 0, 0,      0,  5, 12'h44E, 32'h0,     32'h0);
    add("t2_irq",      32'h20008, 0, 0, 1, 0, 0,      0,  5, 12'h44E, 32'h20008, 32'h0);
    add("t2_req3",     32'h0,     0, 0, 1, 0, 0,      1,  3, 12'h000, 32'h20008, 32'h0);
    add("t2_ack3",     32'h0,     1, 0, 1, 0, 0,      0,  3, 12'h000, 32'h20000, 32'h8);
    add("t2_eoi3",     32'h0,     0, 1, 1, 0, 0,      0,  3, 12'h000, 32'h20000, 32'h0);
    add("t2_req17",    32'h0,     0, 0, 1, 0, 0,      1, 17, 12'h000, 32'h20000, 32'h0);
    add("t2_ack17",    32'h0,     1, 0, 1, 0, 0,      0, 17, 12'h000, 32'h0,     32'h20000);
    add("t2_eoi17",    32'h0,     0, 1, 1, 0, 0,      0, 17, 12'h000, 32'h0,     32'h0);
    add("t5_irq4",     32'h10,    0, 0, 1, 0, 0,      0, 17, 12'h000, 32'h10,    32'h0);
    add("t5_req4",     32'h0,     0, 0, 1, 0, 0,      1,  4, 12'h000, 32'h10,    32'h0);
    add("t5_ack_irq4", 32'h10,    1, 0, 1, 0, 0,      0,  4, 12'h000, 32'h10,    32'h10);
    add("t5_ack_serv", 32'h0,     1, 0, 1, 0, 0,      0,  4, 12'h000, 32'h10,    32'h10);
    add("t5_eoi",      32'h0,     0, 1, 1, 0, 0,      0,  4, 12'h000, 32'h10,    32'h0);
    add("t5_repres",   32'h0,     0, 0, 1, 0, 0,      1,  4, 12'h000, 32'h10,    32'h0);
    add("t5_ack2",     32'h0,     1, 0, 1, 0, 0,      0,  4, 12'h000, 32'h0,     32'h10);
    add("t5_eoi2",     32'h0,     0, 1, 1, 0, 0,      0,  4, 12'h000, 32'h0,     32'h0);
    add("t4_irq12",    32'h1000,  0, 0, 1, 0, 0,      0,  4, 12'h000, 32'h1000,  32'h0);
    add("t4_req12",    32'h0,     0, 0, 1, 0, 0,      1, 12, 12'h000, 32'h1000,  32'h0);
    add("t4_ien_off",  32'h0,     0, 0, 0, 0, 0,      0, 12, 12'h000, 32'h1000,  32'h0);
    add("t4_ien_hold", 32'h0,     0, 0, 0, 0, 0,      0, 12, 12'h000, 32'h1000,  32'h0);
    add("t4_ien_on",   32'h0,     0, 0, 1, 0, 0,      1, 12, 12'h000, 32'h1000,  32'h0);
    add("t4_ack",      32'h0,     1, 0, 1, 0, 0,      0, 12, 12'h000, 32'h0,     32'h1000);
    add("t4_eoi",      32'h0,     0, 1, 1, 0, 0,      0, 12, 12'h000, 32'h0,     32'h0);
    add("t3_mask_irq", 32'h200,   0, 0, 1, 1, 32'h200, 0, 12, 12'h000, 32'h200,  32'h0);
    add("t3_masked",   32'h0,     0, 0, 1, 0, 0,      0, 12, 12'h000, 32'h200,   32'h0);
    add("t3_eoi_idle", 32'h0,     0, 1, 1, 0, 0,      0, 12, 12'h000, 32'h200,   32'h0);
    add("t3_unmask",   32'h0,     0, 0, 1, 1, 0,      0, 12, 12'h000, 32'h200,   32'h0);
    add("t3_req9",     32'h0,     0, 0, 1, 0, 0,      1,  9, 12'h000, 32'h200,   32'h0);
    add("t3_ack9",     32'h0,     1, 0, 1, 0, 0,      0,  9, 12'h000, 32'h0,     32'h200);
    add("t3_eoi9",     32'h0,     0, 1, 1, 0, 0,      0,  9, 12'h000, 32'h0,     32'h0);
    foreach (vecs[k]) begin
      i_irq = vecs[k].irq; i_ack = vecs[k].ack; i_eoi = vecs[k].eoi; i_ien = vecs[k].ien;
      i_mask_we = vecs[k].mwe; i_mask_data = vecs[k].mdata; i_tab_we = 1'b0;
      tick(vecs[k].name);
      check(vecs[k].name, snap(),
            {vecs[k].req, vecs[k].num, vecs[k].vec, vecs[k].pend, vecs[k].ins});
    end
    // serving #20 while #2 arrives
    i_ien = 1'b1;
    tab_write(5'd2, 12'h123);
    tab_write(5'd20, 12'h2AB);
    idle_in(); i_irq = 32'h100000; tick("t6_irq20");
    idle_in(); tick("t6_req20");
    check("t6_req20", snap(), {1'b1, 5'd20, 12'h2AB, 32'h100000, 32'h0});
    i_ack = 1'b1; tick("t6_ack20");
    idle_in(); i_irq = 32'h4; tick("t6_irq2");
    check("t6_irq2", snap(), {1'b0, 5'd20, 12'h2AB, 32'h4, 32'h100000});
    idle_in(); tick("t6_arb2");
`ifdef INTR_NEST_EN
    check("t6_nest_req2", snap(), {1'b1, 5'd2, 12'h123, 32'h4, 32'h100000});
    i_ack = 1'b1; tick("t6_ack2");
    check("t6_stack", snap(), {1'b0, 5'd2, 12'h123, 32'h0, 32'h100004});
    idle_in(); i_eoi = 1'b1; tick("t6_eoi2");
    check("t6_eoi2", snap(), {1'b0, 5'd2, 12'h123, 32'h0, 32'h100000});
    tick("t6_eoi20");
    check("t6_eoi20", snap(), {1'b0, 5'd2, 12'h123, 32'h0, 32'h0});
`else
    check("t6_wait", snap(), {1'b0, 5'd20, 12'h2AB, 32'h4, 32'h100000});
    tick("t6_wait2");
    check("t6_wait2", snap(), {1'b0, 5'd20, 12'h2AB, 32'h4, 32'h100000});
    i_eoi = 1'b1; tick("t6_eoi20");
    check("t6_eoi20", snap(), {1'b0, 5'd20, 12'h2AB, 32'h4, 32'h0});
    idle_in(); tick("t6_req2");
    check("t6_req2", snap(), {1'b1, 5'd2, 12'h123, 32'h4, 32'h0});
    i_ack = 1'b1; tick("t6_ack2");
    idle_in(); i_eoi = 1'b1; tick("t6_eoi2");
`endif
    // reset while a request is presented drops it
    idle_in(); i_irq = 32'h80; tick("rst_irq7");
    idle_in(); tick("rst_req7");
    check1("rst_req7", {31'b0, o_req}, 32'h1);
    reset = 1'b1; tick("rst_mid");
    check("rst_mid", snap(), '0);
    reset = 1'b0;
    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      i_irq = ($urandom_range(0, 3) == 0) ? 32'd1 << $urandom_range(0, 31) : '0;
      i_ack = 1'($urandom_range(0, 1));
      i_eoi = $urandom_range(0, 3) == 0;
      i_ien = $urandom_range(0, 9) != 0;
      i_mask_we = $urandom_range(0, 31) == 0;
      i_mask_data = $urandom & $urandom & $urandom;
      i_tab_we = $urandom_range(0, 7) == 0;
      i_tab_idx = 5'($urandom_range(0, 31));
      i_tab_data = 12'($urandom);
      reset = $urandom_range(0, 499) == 0;
      tick("rand");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
